memshare_alloc_sequencer: RTL and testbench
===========================================

MEMSHARE_ALLOC_SEQUENCER -- requirements
Module: memshare_alloc_sequencer

Interface
REQ-001 SHALL have parameter SHARE_GROUP_SIZE, default 5: number of requestors (G) in a share group.
REQ-002 SHALL have parameter SHARE_COL_CONFIG [G-1:0], default 5'b10101: '1' marks a shared column; '0' marks a private column.
REQ-003 SHALL have parameter RQST_ADDR_BITWIDTH, default 2: width of each requestor's bank address (A); bank count is 2^A.
REQ-004 SHALL have parameter MAX_ALLOC_SEQ_NUM, default 2: maximum allocation sequences (S) per pattern, S>=1.
REQ-005 SHALL have parameter ARR_RQST_TRACK_DEPTH, default 4: pattern FIFO depth (D), D>=2, power of two.
REQ-006 sys_clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 rqst_valid  in  1  arriving request pattern valid.
REQ-009 rqst_ready  out  1  pattern FIFO can accept.
REQ-010 rqst_mask  in  G  per-requestor request flags.
REQ-011 rqst_addr  in  G*A  bank address per requestor; requestor i occupies bits [i*A +: A].
REQ-012 grant_valid  out  1  allocation sequence valid.
REQ-013 grant_ready  in  1  downstream accepts the sequence.
REQ-014 grant_mask  out  G  requestors granted in this sequence.
REQ-015 grant_seq_idx  out  clog2(S) or 1 if S=1  index of the sequence within its pattern.
REQ-016 grant_last  out  1  final sequence of the pattern.
REQ-017 drc_err  out  1  one-cycle pulse: pattern needed more than S sequences.
REQ-018 fifo_level  out  clog2(D)+1  patterns held in the FIFO.

Function
REQ-019 Pattern accepted on a rising edge with rqst_valid&&rqst_ready; rqst_ready = (fifo_level<D), no same-cycle pass-through when full.
REQ-020 Pattern with rqst_mask==0 SHALL be accepted and discarded (not stored, no grant).
REQ-021 FSM states: IDLE, ISSUE.
REQ-022 IDLE: if FIFO non-empty, pop head into pending register (mask+addr), seq counter=0, go ISSUE; else stay.
REQ-023 ISSUE: grant_valid=1; grant_mask, grant_seq_idx and grant_last are combinational from registered pending state only.
REQ-024 Selection: grant_mask includes every pending private requestor, plus per bank the lowest-index pending shared requestor addressing that bank.
REQ-025 grant_last=1 when pending & ~grant_mask == 0 or seq counter == S-1.
REQ-026 Outputs SHALL stay stable while grant_valid&&!grant_ready.
REQ-027 On grant handshake without last: pending <= pending & ~grant_mask, seq counter +1, stay ISSUE.
REQ-028 On grant handshake with last: if FIFO non-empty pop next pattern (seq=0, stay ISSUE, no bubble); else go IDLE.
REQ-029 If residual nonzero at last handshake, drc_err SHALL pulse in the cycle after that edge; residual requestors dropped.
REQ-030 Push and pop in the same cycle: fifo_level unchanged; FIFO pointers wrap modulo D.
REQ-031 Latency: pattern accepted at edge N into empty FIFO while IDLE -> grant_valid high after edge N+2.

Reset
REQ-032 While rst=1: FIFO empty, fifo_level=0, FSM=IDLE, pending cleared, seq counter=0, grant_valid=0, grant_mask=0, grant_last=0, grant_seq_idx=0, drc_err=0, rqst_ready=0.
REQ-033 Reset mid-operation SHALL discard all stored and in-flight patterns; rqst_ready=1 from the first edge after rst deasserts.

Verification (defaults)
REQ-034 Mask 5'b11111, all addr=0, grant_ready=1 -> seq0 grant 5'b01011; seq1 grant 5'b00100 last=1; drc_err pulse (req4 dropped).
REQ-035 Mask 5'b11111, addr req0=0, req2=1, req4=2 -> single grant 5'b11111, seq_idx=0, last=1, no drc_err.
REQ-036 Mask 5'b00101, both addr=3, grant_ready low 5 cycles -> grant 5'b00001 held stable; then 5'b00100 last=1.
REQ-037 grant_ready=0, push 6 patterns -> 1 popped to ISSUE, fifo_level reaches 4, rqst_ready=0; release -> all drain back-to-back in order.
REQ-038 Assert rst during seq1 of a pattern with 2 queued -> all outputs reset, no further grants; mask 5'b00000 push afterwards -> fifo_level stays 0.

Source files
------------

// File: rtl/memshare_alloc_sequencer.sv
// memshare_alloc_sequencer
// Queues request patterns from a share group and breaks each one into
// conflict-free allocation sequences. Private columns are always granted.
// Shared columns are granted one per bank per sequence, lowest index first.
// A pattern that still has requestors left after MAX_ALLOC_SEQ_NUM sequences
// is truncated, and drc_err pulses for one cycle.
module memshare_alloc_sequencer #(
    parameter int                          SHARE_GROUP_SIZE     = 5,
    parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG     = 5'b10101,
    parameter int                          RQST_ADDR_BITWIDTH   = 2,
    parameter int                          MAX_ALLOC_SEQ_NUM    = 2,
    parameter int                          ARR_RQST_TRACK_DEPTH = 4
) (
    input  logic                                             sys_clk,
    input  logic                                             rst,
    input  logic                                             rqst_valid,
    output logic                                             rqst_ready,
    input  logic [SHARE_GROUP_SIZE-1:0]                      rqst_mask,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0]   rqst_addr,
    output logic                                             grant_valid,
    input  logic                                             grant_ready,
    output logic [SHARE_GROUP_SIZE-1:0]                      grant_mask,
    output logic [((MAX_ALLOC_SEQ_NUM > 1) ? $clog2(MAX_ALLOC_SEQ_NUM) : 1)-1:0] grant_seq_idx,
    output logic                                             grant_last,
    output logic                                             drc_err,
    output logic [$clog2(ARR_RQST_TRACK_DEPTH):0]            fifo_level
);

    localparam int G     = SHARE_GROUP_SIZE;
    localparam int A     = RQST_ADDR_BITWIDTH;
    localparam int S     = MAX_ALLOC_SEQ_NUM;
    localparam int D     = ARR_RQST_TRACK_DEPTH;
    localparam int AW    = G * A;
    localparam int SEQ_W = (S > 1) ? $clog2(S) : 1;
    localparam int PTR_W = $clog2(D);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Pattern storage. Entries live in the array until they move into the
    // head register, which pending is always loaded from.
    logic [G-1:0]     mem_mask [D];
    logic [AW-1:0]    mem_addr [D];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] mem_count_reg;
    logic             head_valid_reg;
    logic [G-1:0]     head_mask_reg;
    logic [AW-1:0]    head_addr_reg;

    logic             run_reg;
    state_t           state_reg;
    state_t           state_next;
    logic [G-1:0]     pend_mask_reg;
    logic [AW-1:0]    pend_addr_reg;
    logic [SEQ_W-1:0] seq_reg;
    logic             drc_err_reg;

    logic             push_en;
    logic             head_load;
    logic             pop_head;
    logic             advance;
    logic             drc_set;
    logic [G-1:0]     sel_mask;
    logic [G-1:0]     residual;
    logic             last_int;

    // Level counts the array entries plus the head register. rqst_ready
    // stays low until the first edge after reset is released.
    assign fifo_level = mem_count_reg + LVL_W'(head_valid_reg);
    assign rqst_ready = run_reg && (fifo_level < LVL_W'(D));

    // An all-zero pattern is handshaken but never stored.
    assign push_en    = rqst_valid && rqst_ready && (rqst_mask != '0);

    // The head is refilled whenever it is empty or being consumed.
    assign head_load  = (!head_valid_reg || pop_head) && (mem_count_reg != '0);

    // Selection: a shared requestor wins its bank only if no lower-index
    // pending shared requestor targets the same bank.
    for (genvar gi = 0; gi < G; gi++) begin : g_sel
        logic [A-1:0] my_bank;
        logic         lower_hit;

        assign my_bank = pend_addr_reg[gi*A +: A];

        // Look for a lower-index shared competitor on the same bank.
        always_comb begin
            lower_hit = 1'b0;
            for (int j = 0; j < gi; j++) begin
                if (SHARE_COL_CONFIG[j] && pend_mask_reg[j] &&
                    (pend_addr_reg[j*A +: A] == my_bank)) begin
                    lower_hit = 1'b1;
                end
            end
        end

        assign sel_mask[gi] = pend_mask_reg[gi] &
                              (~SHARE_COL_CONFIG[gi] | ~lower_hit);
    end

    assign residual = pend_mask_reg & ~sel_mask;
    assign last_int = (residual == '0) || (seq_reg == SEQ_W'(S - 1));
    assign drc_err  = drc_err_reg;

    // Array write port. The array has no reset because the pointers and
    // counters define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push_en) begin
            mem_mask[wr_ptr_reg] <= rqst_mask;
            mem_addr[wr_ptr_reg] <= rqst_addr;
        end
    end

    // FIFO pointers, the head register, and the ready enable.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            run_reg        <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_count_reg  <= '0;
            head_valid_reg <= 1'b0;
            head_mask_reg  <= '0;
            head_addr_reg  <= '0;
        end else begin
            run_reg <= 1'b1;
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (head_load) begin
                head_mask_reg  <= mem_mask[rd_ptr_reg];
                head_addr_reg  <= mem_addr[rd_ptr_reg];
                head_valid_reg <= 1'b1;
                rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
            end else if (pop_head) begin
                head_valid_reg <= 1'b0;
            end
            mem_count_reg <= mem_count_reg + LVL_W'(push_en) - LVL_W'(head_load);
        end
    end

    // Sequencer state register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, the pop/advance decisions, and the grant outputs.
    always_comb begin
        state_next    = state_reg;
        pop_head      = 1'b0;
        advance       = 1'b0;
        drc_set       = 1'b0;
        grant_valid   = 1'b0;
        grant_mask    = '0;
        grant_seq_idx = '0;
        grant_last    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (head_valid_reg) begin
                    pop_head   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                grant_valid   = 1'b1;
                grant_mask    = sel_mask;
                grant_seq_idx = seq_reg;
                grant_last    = last_int;
                if (grant_ready) begin
                    if (!last_int) begin
                        advance = 1'b1;
                    end else begin
                        drc_set = (residual != '0);
                        if (head_valid_reg) begin
                            pop_head = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending pattern, sequence counter, and the DRC pulse.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pend_mask_reg <= '0;
            pend_addr_reg <= '0;
            seq_reg       <= '0;
            drc_err_reg   <= 1'b0;
        end else begin
            drc_err_reg <= drc_set;
            if (pop_head) begin
                pend_mask_reg <= head_mask_reg;
                pend_addr_reg <= head_addr_reg;
                seq_reg       <= '0;
            end else if (advance) begin
                pend_mask_reg <= pend_mask_reg & ~sel_mask;
                seq_reg       <= seq_reg + SEQ_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_memshare_alloc_sequencer.sv
// Directed bench for memshare_alloc_sequencer at its default parameters.
module tb_memshare_alloc_sequencer;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rqst_valid = 1'b0;
    logic       rqst_ready;
    logic [4:0] rqst_mask = '0;
    logic [9:0] rqst_addr = '0;
    logic       grant_valid;
    logic       grant_ready = 1'b0;
    logic [4:0] grant_mask;
    logic [0:0] grant_seq_idx;
    logic       grant_last;
    logic       drc_err;
    logic [2:0] fifo_level;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic       mon_en = 1'b0;
    logic [4:0] mon_mask [$];
    int         mon_cyc [$];
    logic [4:0] exp_m [6];

    memshare_alloc_sequencer dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .rqst_valid    (rqst_valid),
        .rqst_ready    (rqst_ready),
        .rqst_mask     (rqst_mask),
        .rqst_addr     (rqst_addr),
        .grant_valid   (grant_valid),
        .grant_ready   (grant_ready),
        .grant_mask    (grant_mask),
        .grant_seq_idx (grant_seq_idx),
        .grant_last    (grant_last),
        .drc_err       (drc_err),
        .fifo_level    (fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record each grant handshake that the next rising edge will take.
    always @(negedge sys_clk) begin
        if (mon_en && grant_valid && grant_ready) begin
            mon_mask.push_back(grant_mask);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic push(input logic [4:0] m, input logic [9:0] a);
        bit done;
        int k;
        done = 1'b0;
        k = 0;
        rqst_valid = 1'b1;
        rqst_mask  = m;
        rqst_addr  = a;
        while (!done && k < 100) begin
            if (rqst_ready) done = 1'b1;
            step(1);
            k++;
        end
        rqst_valid = 1'b0;
        rqst_mask  = '0;
        rqst_addr  = '0;
        if (!done) check_eq("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_gv(input int lim);
        int k;
        k = 0;
        while (!grant_valid && k < lim) begin
            step(1);
            k++;
        end
        check_eq("wait_grant", grant_valid, 1);
    endtask

    initial begin
        exp_m[0] = 5'b00001;
        exp_m[1] = 5'b00010;
        exp_m[2] = 5'b00100;
        exp_m[3] = 5'b01000;
        exp_m[4] = 5'b10000;
        exp_m[5] = 5'b00011;

        // Reset state.
        step(2);
        check_eq("rst_gvalid", grant_valid, 0);
        check_eq("rst_gmask", grant_mask, 0);
        check_eq("rst_glast", grant_last, 0);
        check_eq("rst_gseq", grant_seq_idx, 0);
        check_eq("rst_drc", drc_err, 0);
        check_eq("rst_ready", rqst_ready, 0);
        check_eq("rst_level", fifo_level, 0);
        rst = 1'b0;
        check_eq("ready_pre_edge", rqst_ready, 0);
        step(1);
        check_eq("ready_post_edge", rqst_ready, 1);

        // All five requestors on bank 0: two sequences, with req4 dropped.
        grant_ready = 1'b1;
        push(5'b11111, 10'd0);
        check_eq("lat_n", grant_valid, 0);
        step(1);
        check_eq("lat_n1", grant_valid, 0);
        step(1);
        check_eq("lat_n2", grant_valid, 1);
        check_eq("t34_s0_mask", grant_mask, 5'b01011);
        check_eq("t34_s0_seq", grant_seq_idx, 0);
        check_eq("t34_s0_last", grant_last, 0);
        step(1);
        check_eq("t34_s1_mask", grant_mask, 5'b00100);
        check_eq("t34_s1_seq", grant_seq_idx, 1);
        check_eq("t34_s1_last", grant_last, 1);
        check_eq("t34_s1_drc", drc_err, 0);
        step(1);
        check_eq("t34_idle", grant_valid, 0);
        check_eq("t34_drc", drc_err, 1);
        step(1);
        check_eq("t34_drc_end", drc_err, 0);

        // Shared requestors on distinct banks: a single full grant.
        push(5'b11111, 10'b10_00_01_00_00);
        step(2);
        check_eq("t35_mask", grant_mask, 5'b11111);
        check_eq("t35_seq", grant_seq_idx, 0);
        check_eq("t35_last", grant_last, 1);
        step(1);
        check_eq("t35_idle", grant_valid, 0);
        check_eq("t35_drc", drc_err, 0);

        // Backpressure: the first grant holds steady while grant_ready is low.
        grant_ready = 1'b0;
        push(5'b00101, 10'b00_00_11_00_11);
        step(2);
        for (int i = 0; i < 5; i++) begin
            check_eq("t36_hold_valid", grant_valid, 1);
            check_eq("t36_hold_mask", grant_mask, 5'b00001);
            check_eq("t36_hold_last", grant_last, 0);
            step(1);
        end
        grant_ready = 1'b1;
        step(1);
        check_eq("t36_s1_mask", grant_mask, 5'b00100);
        check_eq("t36_s1_seq", grant_seq_idx, 1);
        check_eq("t36_s1_last", grant_last, 1);
        step(1);
        check_eq("t36_idle", grant_valid, 0);
        check_eq("t36_drc", drc_err, 0);
        grant_ready = 1'b0;

        // Fill the FIFO, then drain it in order.
        for (int i = 0; i < 5; i++) push(exp_m[i], 10'd0);
        check_eq("t37_level", fifo_level, 4);
        check_eq("t37_ready", rqst_ready, 0);
        check_eq("t37_head_mask", grant_mask, 5'b00001);
        step(3);
        check_eq("t37_level_hold", fifo_level, 4);
        check_eq("t37_mask_hold", grant_mask, 5'b00001);
        mon_en = 1'b1;
        grant_ready = 1'b1;
        push(exp_m[5], 10'd0);
        for (int k = 0; k < 50 && mon_mask.size() < 6; k++) step(1);
        mon_en = 1'b0;
        check_eq("t37_count", mon_mask.size(), 6);
        if (mon_mask.size() == 6) begin
            for (int i = 0; i < 6; i++) check_eq("t37_order", mon_mask[i], exp_m[i]);
            for (int i = 1; i < 6; i++) check_eq("t37_gap", mon_cyc[i] - mon_cyc[i-1], 1);
        end
        step(2);
        check_eq("t37_empty", fifo_level, 0);
        check_eq("t37_idle", grant_valid, 0);
        check_eq("t37_drc", drc_err, 0);
        grant_ready = 1'b0;

        // Reset during the second sequence while two patterns are queued.
        push(5'b11111, 10'd0);
        push(5'b00010, 10'd0);
        push(5'b01000, 10'd0);
        wait_gv(10);
        check_eq("t38_s0_mask", grant_mask, 5'b01011);
        grant_ready = 1'b1;
        step(1);
        grant_ready = 1'b0;
        check_eq("t38_s1_seq", grant_seq_idx, 1);
        check_eq("t38_s1_mask", grant_mask, 5'b00100);
        check_eq("t38_level", fifo_level, 2);
        rst = 1'b1;
        #1;
        check_eq("t38_rst_valid", grant_valid, 0);
        check_eq("t38_rst_mask", grant_mask, 0);
        check_eq("t38_rst_seq", grant_seq_idx, 0);
        check_eq("t38_rst_last", grant_last, 0);
        check_eq("t38_rst_level", fifo_level, 0);
        check_eq("t38_rst_ready", rqst_ready, 0);
        check_eq("t38_rst_drc", drc_err, 0);
        step(2);
        rst = 1'b0;
        check_eq("t38_ready_pre", rqst_ready, 0);
        step(1);
        check_eq("t38_ready_post", rqst_ready, 1);
        push(5'b00000, 10'd0);
        check_eq("t38_zero_level", fifo_level, 0);
        grant_ready = 1'b1;
        step(3);
        check_eq("t38_no_grant", grant_valid, 0);
        check_eq("t38_zero_level2", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
